// File: rtl/xillybus_lite_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xillybus_lite_regbank: host register bank with countdown timer, irq and     |
// | 4-deep mailbox FIFO.                                       Revision 1.0     |
// +----------------------------------------------------------------------------+
module xillybus_lite_regbank #(
  parameter logic [31:0] ID_VALUE = 32'h584C_0001
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq
);

  localparam logic [2:0] c_REG_ID      = 3'd0;
  localparam logic [2:0] c_REG_SCRATCH = 3'd1;
  localparam logic [2:0] c_REG_CTRL    = 3'd2;
  localparam logic [2:0] c_REG_STATUS  = 3'd3;
  localparam logic [2:0] c_REG_LOAD    = 3'd4;
  localparam logic [2:0] c_REG_COUNT   = 3'd5;
  localparam logic [2:0] c_REG_EVENTS  = 3'd6;
  localparam logic [2:0] c_REG_MAILBOX = 3'd7;
  localparam logic [2:0] c_FIFO_DEPTH  = 3'd4;

  logic [31:0] scratch_q, scratch_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] events_q, events_d;
  logic        pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  level_q, level_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mem_q [4];

  logic [2:0]  w_idx;
  logic        w_wr_sel, w_rd_sel;
  logic        w_expiry;
  logic        w_w1c;
  logic        w_fifo_full, w_fifo_empty;
  logic        w_push_req, w_pop_req;
  logic        w_push, w_pop;
  logic [31:0] w_load_merged;
  logic [31:0] w_status;
  logic [31:0] w_rd_mux;
  logic        unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Accesses are gated off during reset so nothing they touch can leak through.
  assign w_idx        = user_addr[4:2];
  assign w_wr_sel     = user_wren & ~user_rst;
  assign w_rd_sel     = user_rden & ~user_rst;
  assign unused_addr  = ^{user_addr[31:5], user_addr[1:0]};

  assign w_fifo_full  = (level_q == c_FIFO_DEPTH);
  assign w_fifo_empty = (level_q == 3'd0);
  assign w_push_req   = w_wr_sel & (w_idx == c_REG_MAILBOX) & (|user_wstrb);
  assign w_pop_req    = w_rd_sel & (w_idx == c_REG_MAILBOX);
  assign w_pop        = w_pop_req & ~w_fifo_empty;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign w_push       = w_push_req & (~w_fifo_full | w_pop);

  assign w_expiry      = ctrl_q[0] & (count_q == 32'd1);
  assign w_w1c         = w_wr_sel & (w_idx == c_REG_STATUS) & user_wstrb[0];
  assign w_load_merged = merge_bytes(load_q, user_wr_data, user_wstrb);
  assign w_status      = {26'd0, w_fifo_empty, level_q, overflow_q, pending_q};

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_idx)
      c_REG_ID:      w_rd_mux = ID_VALUE;
      c_REG_SCRATCH: w_rd_mux = scratch_q;
      c_REG_CTRL:    w_rd_mux = {29'd0, ctrl_q};
      c_REG_STATUS:  w_rd_mux = w_status;
      c_REG_LOAD:    w_rd_mux = load_q;
      c_REG_COUNT:   w_rd_mux = count_q;
      c_REG_EVENTS:  w_rd_mux = events_q;
      c_REG_MAILBOX: w_rd_mux = w_fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
      default:       w_rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    events_d   = events_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;

    if (w_rd_sel) rd_data_d = w_rd_mux;

    if (w_wr_sel && w_idx == c_REG_SCRATCH)
      scratch_d = merge_bytes(scratch_q, user_wr_data, user_wstrb);
    if (w_wr_sel && w_idx == c_REG_CTRL && user_wstrb[0])
      ctrl_d = user_wr_data[2:0];
    if (w_wr_sel && w_idx == c_REG_LOAD)
      load_d = w_load_merged;

    // A LOAD write overrides the timer; any expiry this cycle is still counted.
    if (w_wr_sel && w_idx == c_REG_LOAD)
      count_d = w_load_merged;
    else if (w_expiry)
      count_d = ctrl_q[2] ? load_q : 32'd0;
    else if (ctrl_q[0] && count_q != 32'd0)
      count_d = count_q - 32'd1;

    events_d   = events_q + {31'd0, w_expiry};
    pending_d  = w_expiry | (pending_q & ~(w_w1c & user_wr_data[0]));
    overflow_d = (w_push_req & w_fifo_full & ~w_pop)
               | (overflow_q & ~(w_w1c & user_wr_data[1]));

    if (w_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    level_d = level_q + {2'd0, w_push} - {2'd0, w_pop};
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      scratch_q  <= '0;
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      events_q   <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      events_q   <= events_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= user_wr_data;
  end

  assign user_rd_data = rd_data_q;
  assign user_irq     = pending_q & ctrl_q[1];

endmodule
`default_nettype wire
